// File: rtl/npu_pkg.sv
// Shared NPU types and defaults: pixel type and the kernel geometry used by conv_unit.
package npu_pkg;
  localparam int PIX_W   = 8;
  localparam int K_H_DEF = 3;
  localparam int K_W_DEF = 3;

  typedef logic [PIX_W-1:0] pix_t;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// One raster line of pixels, addressed by column; read-before-write in the same cycle.
module line_buffer
  import npu_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);

  pix_t mem [DEPTH];

  // Combinational read returns the old word while the edge writes the new one.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming K_H x K_W sliding-window generator (stride 1, no padding) feeding conv_unit.
module conv_window_gen
  import npu_pkg::*;
#(
  parameter int K_H   = K_H_DEF,
  parameter int K_W   = K_W_DEF,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  pix_t                      pix_i,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output pix_t [0:K_H-1][0:K_W-1]   win_o,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic                      win_last
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam int NLB = K_H - 1;

  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  pix_t [NLB-1:0]  lb_rd;
  pix_t [NLB-1:0]  lb_wr;
  logic            accept;
  logic            col_end;
  logic            row_end;
  logic            emit;

  assign pix_ready = !win_valid | win_ready;
  assign accept    = pix_valid & pix_ready & !clr;
  assign col_end   = (col == CW'(IMG_W-1));
  assign row_end   = (row == RW'(IMG_H-1));
  assign emit      = (row >= RW'(K_H-1)) && (col >= CW'(K_W-1));

  // Line k holds row r-1-k; each line's evicted pixel moves down into the next line.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_wr[k] = pix_i;
    end else begin : g_chain
      assign lb_wr[k] = lb_rd[k-1];
    end

    line_buffer #(
      .DEPTH (IMG_W),
      .AW    (CW)
    ) u_lb (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (lb_wr[k]),
      .rdata (lb_rd[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window shifts left on every accepted pixel, valid or not, so it is primed by the time
  // the row reaches column K_W-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_o <= '0;
    end else if (clr) begin
      win_o <= '0;
    end else if (accept) begin
      for (int i = 0; i < K_H; i++) begin
        for (int j = 0; j < K_W-1; j++) begin
          win_o[i][j] <= win_o[i][j+1];
        end
      end
      for (int i = 0; i < K_H-1; i++) begin
        win_o[i][K_W-1] <= lb_rd[K_H-2-i];
      end
      win_o[K_H-1][K_W-1] <= pix_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (clr) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (accept) begin
      win_valid <= emit;
      win_last  <= emit & row_end & col_end;
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen (5x4 image, 3x3 window) against an anchor-indexed model.
module tb_conv_window_gen;
  import npu_pkg::*;

  localparam int KH = 3, KW = 3, W = 5, H = 4;
  localparam int FRAME = W * H;
  localparam int NWIN  = (H - KH + 1) * (W - KW + 1);

  typedef logic [0:KH-1][0:KW-1][7:0] win_t;

  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
  logic pix_valid = 1'b0, win_ready = 1'b0;
  pix_t pix_i = '0;
  logic pix_ready, win_valid, win_last;
  win_t win_o;

  int checks = 0, errors = 0;

  pix_t stim[$];
  win_t exp_win[$];
  bit   exp_last[$];
  win_t obs_win[$];
  bit   obs_last[$];
  int   obs_cyc[$];
  int   acc_cyc[$];
  win_t bp_win[$];
  bit   bp_pr[$];

  always #5 clk = ~clk;

  conv_window_gen #(.K_H(KH), .K_W(KW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .pix_i     (pix_i),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win_o     (win_o),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last)
  );

  // Every window anchored at (r,c) in every frame of stim, in raster order of anchors.
  task automatic build_model();
    win_t w;
    exp_win.delete();
    exp_last.delete();
    for (int f = 0; f < stim.size() / FRAME; f++)
      for (int r = 0; r <= H - KH; r++)
        for (int c = 0; c <= W - KW; c++) begin
          for (int i = 0; i < KH; i++)
            for (int j = 0; j < KW; j++)
              w[i][j] = stim[f*FRAME + (r+i)*W + c + j];
          exp_win.push_back(w);
          exp_last.push_back((r == H - KH) && (c == W - KW));
        end
  endtask

  task automatic load_ramp(input int frames);
    stim.delete();
    for (int n = 0; n < frames * FRAME; n++) stim.push_back(pix_t'(n % FRAME));
  endtask

  // Drives stim with random gaps/readiness and records what the DUT hands out.
  task automatic run_stream(input int gap_pct, input int rdy_pct, input int hold_idx,
                            input int hold_len, output bit done);
    int pi, cyc, idle, hold_left;
    bit held, in_hold;
    pi = 0; cyc = 0; idle = 0; hold_left = 0; held = 0;
    obs_win.delete(); obs_last.delete(); obs_cyc.delete(); acc_cyc.delete();
    bp_win.delete(); bp_pr.delete();
    while (idle < 3 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      pix_valid = (pi < stim.size()) && ($urandom_range(99) >= gap_pct);
      pix_i = pix_valid ? stim[pi] : pix_t'($urandom);
      if (!held && hold_idx == obs_win.size() && win_valid) begin
        held = 1; hold_left = hold_len;
      end
      in_hold = (hold_left > 0);
      if (in_hold) begin
        win_ready = 1'b0;
        hold_left--;
      end else begin
        win_ready = ($urandom_range(99) < rdy_pct);
      end
      #1;
      if (in_hold) begin
        bp_win.push_back(win_o);
        bp_pr.push_back(pix_ready);
      end
      if (win_valid && win_ready) begin
        obs_win.push_back(win_o);
        obs_last.push_back(win_last);
        obs_cyc.push_back(cyc);
      end
      if (pix_valid && pix_ready) begin
        acc_cyc.push_back(cyc);
        pi++;
      end
      idle = (pi == stim.size() && !win_valid) ? idle + 1 : 0;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    win_ready = 1'b0;
    done = (idle >= 3);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (win_valid !== 1'b0 || win_last !== 1'b0) begin
      errors++; $display("FAIL reset_flags: valid=%b last=%b, want 0 0", win_valid, win_last);
    end
    checks++;
    if (win_o !== '0) begin
      errors++; $display("FAIL reset_win: got %h want 0", win_o);
    end
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", pix_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    bit done;
    int nlast;
    win_t first_w, last_w;
    first_w = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
    last_w  = {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19};
    load_ramp(1);
    build_model();
    run_stream(0, 100, -1, 0, done);
    checks++;
    if (!done) begin errors++; $display("FAIL stream_timeout: frame did not drain"); end
    checks++;
    if (obs_win.size() != NWIN) begin
      errors++; $display("FAIL stream_count: got %0d windows want %0d", obs_win.size(), NWIN);
    end
    if (obs_win.size() == NWIN && acc_cyc.size() == FRAME) begin
      checks++;
      if (obs_win[0] !== first_w) begin
        errors++; $display("FAIL stream_first: got %h want %h", obs_win[0], first_w);
      end
      checks++;
      if (obs_cyc[0] != acc_cyc[12] + 1) begin
        errors++; $display("FAIL stream_latency: window at cyc %0d, pixel 12 at cyc %0d, want +1",
                           obs_cyc[0], acc_cyc[12]);
      end
      checks++;
      if (obs_win[NWIN-1] !== last_w || obs_last[NWIN-1] !== 1'b1) begin
        errors++; $display("FAIL stream_last: got %h last=%b want %h last=1",
                           obs_win[NWIN-1], obs_last[NWIN-1], last_w);
      end
    end
    nlast = 0;
    foreach (obs_last[k]) nlast += int'(obs_last[k]);
    checks++;
    if (nlast != 1) begin errors++; $display("FAIL stream_last_count: got %0d want 1", nlast); end
  endtask

  task automatic test_backpressure();
    bit done;
    win_t w2;
    w2 = {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
    load_ramp(1);
    build_model();
    run_stream(0, 100, 1, 4, done);
    checks++;
    if (!done || bp_win.size() != 4) begin
      errors++; $display("FAIL bp_hold: done=%b hold cycles=%0d want 4", done, bp_win.size());
    end
    foreach (bp_win[k]) begin
      checks++;
      if (bp_win[k] !== w2 || bp_pr[k] !== 1'b0) begin
        errors++; $display("FAIL bp_stable[%0d]: win=%h pix_ready=%b want %h 0",
                           k, bp_win[k], bp_pr[k], w2);
      end
    end
    checks++;
    if (obs_win.size() != exp_win.size()) begin
      errors++; $display("FAIL bp_count: got %0d want %0d", obs_win.size(), exp_win.size());
    end
    for (int k = 0; k < exp_win.size() && k < obs_win.size(); k++) begin
      checks++;
      if (obs_win[k] !== exp_win[k] || obs_last[k] !== exp_last[k]) begin
        errors++; $display("FAIL bp_win[%0d]: got %h/%b want %h/%b",
                           k, obs_win[k], obs_last[k], exp_win[k], exp_last[k]);
      end
    end
  endtask

  task automatic test_gaps();
    bit done;
    int nlast;
    stim.delete();
    for (int n = 0; n < 3 * FRAME; n++) stim.push_back(pix_t'($urandom));
    build_model();
    run_stream(35, 60, -1, 0, done);
    checks++;
    if (!done || obs_win.size() != exp_win.size()) begin
      errors++; $display("FAIL gaps_count: done=%b got %0d want %0d", done, obs_win.size(),
                         exp_win.size());
    end
    for (int k = 0; k < exp_win.size() && k < obs_win.size(); k++) begin
      checks++;
      if (obs_win[k] !== exp_win[k] || obs_last[k] !== exp_last[k]) begin
        errors++; $display("FAIL gaps_win[%0d]: got %h/%b want %h/%b",
                           k, obs_win[k], obs_last[k], exp_win[k], exp_last[k]);
      end
    end
    nlast = 0;
    foreach (obs_last[k]) nlast += int'(obs_last[k]);
    checks++;
    if (nlast != 3) begin errors++; $display("FAIL gaps_last_count: got %0d want 3", nlast); end
  endtask

  // Abort after n pixels (mid-frame) with rst_n or clr, then replay a full frame.
  task automatic test_abort(input bit use_clr, input int npix);
    bit done;
    load_ramp(1);
    build_model();
    for (int n = 0; n < npix; n++) begin
      @(negedge clk);
      pix_valid = 1'b1; pix_i = pix_t'(n); win_ready = 1'b1;
    end
    @(negedge clk);
    pix_valid = 1'b0; win_ready = 1'b0;
    if (npix > 12) begin
      #1;
      checks++;
      if (win_valid !== 1'b1) begin
        errors++; $display("FAIL abort_pre: win_valid=%b want 1 before abort", win_valid);
      end
    end
    if (!use_clr) begin
      #2 rst_n = 1'b0;
      #1;
    end else begin
      clr = 1'b1; pix_valid = 1'b1; pix_i = 8'hAA;
      @(negedge clk);
      clr = 1'b0; pix_valid = 1'b0;
      #1;
    end
    checks++;
    if (win_valid !== 1'b0 || win_last !== 1'b0) begin
      errors++; $display("FAIL abort_%s_%0d: valid=%b last=%b want 0 0",
                         use_clr ? "clr" : "rst", npix, win_valid, win_last);
    end
    if (!use_clr) begin
      @(negedge clk);
      rst_n = 1'b1;
    end
    run_stream(0, 100, -1, 0, done);
    checks++;
    if (!done || obs_win.size() != NWIN) begin
      errors++; $display("FAIL abort_restart_count: done=%b got %0d want %0d", done,
                         obs_win.size(), NWIN);
    end
    for (int k = 0; k < NWIN && k < obs_win.size(); k++) begin
      checks++;
      if (obs_win[k] !== exp_win[k] || obs_last[k] !== exp_last[k]) begin
        errors++; $display("FAIL abort_restart_win[%0d]: got %h/%b want %h/%b",
                           k, obs_win[k], obs_last[k], exp_win[k], exp_last[k]);
      end
    end
  endtask

  task automatic test_range();
    bit done;
    int s;
    stim.delete();
    for (int n = 0; n < FRAME; n++) stim.push_back(8'hFF);
    run_stream(20, 70, -1, 0, done);
    checks++;
    if (!done || obs_win.size() != NWIN) begin
      errors++; $display("FAIL range_count: done=%b got %0d want %0d", done, obs_win.size(), NWIN);
    end
    foreach (obs_win[k]) begin
      s = 0;
      for (int i = 0; i < KH; i++)
        for (int j = 0; j < KW; j++) s += -1 * int'(obs_win[k][i][j]);
      checks++;
      if (s != -2295) begin
        errors++; $display("FAIL range_sum[%0d]: got %0d want -2295 (win %h)", k, s, obs_win[k]);
      end
    end
  endtask

  task automatic test_integration();
    bit done;
    int s;
    load_ramp(1);
    run_stream(10, 80, -1, 0, done);
    s = 0;
    if (obs_win.size() > 0)
      for (int i = 0; i < KH; i++)
        for (int j = 0; j < KW; j++) s += int'(obs_win[0][i][j]);
    checks++;
    if (!done || s != 54) begin
      errors++; $display("FAIL integ_sum: done=%b got %0d want 54", done, s);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_gaps();
    test_abort(1'b0, 10);
    test_abort(1'b1, 10);
    test_abort(1'b0, 13);
    test_abort(1'b1, 13);
    test_range();
    test_integration();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
